fir_param: RTL and testbench

FIR_PARAM -- requirements
Module: fir_param

---
 rtl/fir_param.sv | 269 ++++++++++++++++++++++++++
 tb/tb_fir_param.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_param.sv
// Parameterized FIR filter: AXI-lite control/coefficient registers, AXI-stream
// sample in/out, one tap multiply-accumulate per cycle over a circular sample buffer.
module fir_param #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_TAPS   = 16
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rvalid,
  input  logic                   rready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic                   ss_tlast,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast
);
  localparam int AW   = pADDR_WIDTH;
  localparam int DW   = pDATA_WIDTH;
  localparam int ACCW = 2 * pDATA_WIDTH;
  localparam int TW   = $clog2(pMAX_TAPS + 1);
  localparam int PW   = $clog2(pMAX_TAPS);

  localparam logic [AW-1:0] A_CTRL  = AW'('h00);
  localparam logic [AW-1:0] A_LEN   = AW'('h10);
  localparam logic [AW-1:0] A_TAPS  = AW'('h14);
  localparam logic [AW-1:0] A_SHIFT = AW'('h18);
  localparam logic [AW-1:0] A_COEF  = AW'('h40);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FETCH, S_MAC, S_OUT, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic                   aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
  logic [AW-1:0]          aw_addr_q, aw_addr_d;
  logic [DW-1:0]          w_data_q, w_data_d;
  logic                   rvalid_q, rvalid_d;
  logic [DW-1:0]          rdata_q, rdata_d, rd_val;
  logic                   ap_start_q, ap_start_d, ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d, tlast_err_q, tlast_err_d;
  logic [31:0]            data_length_q, data_length_d;
  logic [TW-1:0]          tap_num_q, tap_num_d;
  logic [4:0]             out_shift_q, out_shift_d;
  logic signed [DW-1:0]   coef_q [pMAX_TAPS];
  logic signed [DW-1:0]   coef_d [pMAX_TAPS];
  logic signed [DW-1:0]   sbuf_q [pMAX_TAPS];
  logic signed [DW-1:0]   sbuf_d [pMAX_TAPS];
  logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d, wp_nxt;
  logic [TW-1:0]          k_q, k_d;
  logic [31:0]            cnt_q, cnt_d;
  logic signed [ACCW-1:0] acc_q, acc_d, prod, acc_sum;
  logic                   sm_tvalid_q, sm_tvalid_d, sm_tlast_q, sm_tlast_d;
  logic [DW-1:0]          sm_tdata_q, sm_tdata_d;
  logic                   last_idx;

  function automatic logic is_coef(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = (a - A_COEF) >> 2;
    return (a >= A_COEF) && (a[1:0] == 2'b00) && (off < AW'(pMAX_TAPS));
  endfunction

  function automatic logic [PW-1:0] coef_idx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = (a - A_COEF) >> 2;
    return off[PW-1:0];
  endfunction

  assign awready   = ~aw_vld_q & ~axis_rst;
  assign wready    = ~w_vld_q & ~axis_rst;
  assign arready   = ~rvalid_q & ~axis_rst;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign ss_tready = (state_q == S_FETCH);
  assign sm_tvalid = sm_tvalid_q;
  assign sm_tdata  = sm_tdata_q;
  assign sm_tlast  = sm_tlast_q;

  always_comb begin
    rd_val = '0;
    if (araddr == A_CTRL)       rd_val = DW'({tlast_err_q, ap_idle_q, ap_done_q, ap_start_q});
    else if (araddr == A_LEN)   rd_val = DW'(data_length_q);
    else if (araddr == A_TAPS)  rd_val = DW'(tap_num_q);
    else if (araddr == A_SHIFT) rd_val = DW'(out_shift_q);
    else if (is_coef(araddr))   rd_val = coef_q[coef_idx(araddr)];
  end

  always_comb begin
    state_d       = state_q;
    aw_vld_d      = aw_vld_q;
    aw_addr_d     = aw_addr_q;
    w_vld_d       = w_vld_q;
    w_data_d      = w_data_q;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    ap_start_d    = 1'b0;
    ap_done_d     = ap_done_q;
    ap_idle_d     = ap_idle_q;
    tlast_err_d   = tlast_err_q;
    data_length_d = data_length_q;
    tap_num_d     = tap_num_q;
    out_shift_d   = out_shift_q;
    coef_d        = coef_q;
    sbuf_d        = sbuf_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    k_d           = k_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    sm_tvalid_d   = sm_tvalid_q;
    sm_tdata_d    = sm_tdata_q;
    sm_tlast_d    = sm_tlast_q;
    wp_nxt        = (wptr_q == PW'(pMAX_TAPS - 1)) ? '0 : wptr_q + PW'(1);
    prod          = ACCW'(coef_q[k_q[PW-1:0]]) * ACCW'(sbuf_q[rptr_q]);
    acc_sum       = acc_q + prod;
    last_idx      = (cnt_q == data_length_q - 32'd1);

    if (awvalid && awready) begin
      aw_vld_d  = 1'b1;
      aw_addr_d = awaddr;
    end
    if (wvalid && wready) begin
      w_vld_d  = 1'b1;
      w_data_d = wdata;
    end
    // Commit once both halves are latched; config writes only land while idle.
    if (aw_vld_q && w_vld_q) begin
      aw_vld_d = 1'b0;
      w_vld_d  = 1'b0;
      if (aw_addr_q == A_CTRL) begin
        if (w_data_q[0] && ap_idle_q) ap_start_d = 1'b1;
      end else if (ap_idle_q) begin
        if (aw_addr_q == A_LEN) data_length_d = 32'(w_data_q);
        else if (aw_addr_q == A_TAPS) begin
          if (w_data_q == '0)                    tap_num_d = TW'(1);
          else if (w_data_q > DW'(pMAX_TAPS))    tap_num_d = TW'(pMAX_TAPS);
          else                                   tap_num_d = w_data_q[TW-1:0];
        end
        else if (aw_addr_q == A_SHIFT) out_shift_d = w_data_q[4:0];
        else if (is_coef(aw_addr_q))   coef_d[coef_idx(aw_addr_q)] = w_data_q;
      end
    end

    if (arvalid && arready) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      if (araddr == A_CTRL) ap_done_d = 1'b0;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: if (ap_start_q) begin
        state_d     = S_CLR;
        ap_idle_d   = 1'b0;
        tlast_err_d = 1'b0;
      end
      S_CLR: begin
        for (int i = 0; i < pMAX_TAPS; i++) sbuf_d[i] = '0;
        wptr_d  = PW'(pMAX_TAPS - 1);
        cnt_d   = '0;
        state_d = (data_length_q == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: if (ss_tvalid) begin
        sbuf_d[wp_nxt] = ss_tdata;
        wptr_d  = wp_nxt;
        rptr_d  = wp_nxt;
        k_d     = '0;
        acc_d   = '0;
        if (ss_tlast != last_idx) tlast_err_d = 1'b1;
        state_d = S_MAC;
      end
      // Walk backwards from the newest sample, one tap per cycle.
      S_MAC: begin
        acc_d  = acc_sum;
        rptr_d = (rptr_q == '0) ? PW'(pMAX_TAPS - 1) : rptr_q - PW'(1);
        k_d    = k_q + TW'(1);
        if (k_q == tap_num_q - TW'(1)) begin
          sm_tvalid_d = 1'b1;
          sm_tdata_d  = DW'(acc_sum >>> out_shift_q);
          sm_tlast_d  = last_idx;
          state_d     = S_OUT;
        end
      end
      S_OUT: if (sm_tready) begin
        sm_tvalid_d = 1'b0;
        sm_tlast_d  = 1'b0;
        if (sm_tlast_q) state_d = S_DONE;
        else begin
          cnt_d   = cnt_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        ap_done_d = 1'b1;
        ap_idle_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q       <= S_IDLE;
      aw_vld_q      <= 1'b0;
      aw_addr_q     <= '0;
      w_vld_q       <= 1'b0;
      w_data_q      <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      ap_start_q    <= 1'b0;
      ap_done_q     <= 1'b0;
      ap_idle_q     <= 1'b1;
      tlast_err_q   <= 1'b0;
      data_length_q <= '0;
      tap_num_q     <= TW'(pMAX_TAPS);
      out_shift_q   <= '0;
      for (int i = 0; i < pMAX_TAPS; i++) begin
        coef_q[i] <= '0;
        sbuf_q[i] <= '0;
      end
      wptr_q        <= '0;
      rptr_q        <= '0;
      k_q           <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      sm_tvalid_q   <= 1'b0;
      sm_tdata_q    <= '0;
      sm_tlast_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      aw_vld_q      <= aw_vld_d;
      aw_addr_q     <= aw_addr_d;
      w_vld_q       <= w_vld_d;
      w_data_q      <= w_data_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      ap_start_q    <= ap_start_d;
      ap_done_q     <= ap_done_d;
      ap_idle_q     <= ap_idle_d;
      tlast_err_q   <= tlast_err_d;
      data_length_q <= data_length_d;
      tap_num_q     <= tap_num_d;
      out_shift_q   <= out_shift_d;
      coef_q        <= coef_d;
      sbuf_q        <= sbuf_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      k_q           <= k_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      sm_tvalid_q   <= sm_tvalid_d;
      sm_tdata_q    <= sm_tdata_d;
      sm_tlast_q    <= sm_tlast_d;
    end
  end
endmodule

// File: tb/tb_fir_param.sv
// Self-checking bench for fir_param: direct-convolution reference model,
// randomized AXI-lite ordering, coefficients, samples and output backpressure.
module tb_fir_param;
  localparam int M = 16;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [31:0] ss_tdata = '0, sm_tdata;
  logic        ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
  logic        sm_tvalid, sm_tready = 1'b0, sm_tlast;

  fir_param #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pMAX_TAPS(M)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tlast(ss_tlast),
    .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast)
  );

  always #5 axis_clk = ~axis_clk;

  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  int cf [M];
  int tapn, shft, exp_lat;
  int x_q[$];
  bit l_q[$];
  int y_got[$];
  bit last_got[$];
  int stall_bad, lat_bad;

  task automatic step();
    @(posedge axis_clk); #1;
  endtask

  // Reference output: plain convolution with a 64-bit wrapping accumulator.
  function automatic int model_y(input int n);
    longint acc;
    acc = 0;
    for (int k = 0; k < tapn; k++)
      if (n - k >= 0) acc += longint'(cf[k]) * longint'(x_q[n - k]);
    return int'(acc >>> shft);
  endfunction

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int order, n;
    bit ap, wp, af, wf;
    order = $urandom_range(0, 2);
    ap = 1; wp = 1; n = 0;
    awaddr = a; wdata = d;
    awvalid = (order != 2);
    wvalid  = (order != 1);
    while ((ap || wp) && n < 50) begin
      af = awvalid && awready;
      wf = wvalid && wready;
      step(); n++;
      if (af) begin awvalid = 0; ap = 0; end
      if (wf) begin wvalid = 0; wp = 0; end
      if (ap && !awvalid) awvalid = 1;
      if (wp && !wvalid) wvalid = 1;
    end
    awvalid = 0; wvalid = 0;
    if (ap || wp) begin
      n_total++;
      $display("FAIL axi_write_timeout addr=%h: handshake never completed, required completion", a);
    end
    step();
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1; n = 0;
    while (!arready && n < 50) begin step(); n++; end
    step();
    arvalid = 0;
    repeat ($urandom_range(0, 2)) step();
    rready = 1; n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    d = rvalid ? rdata : 32'hdead_beef;
    if (!rvalid) begin
      n_total++;
      $display("FAIL axi_read_timeout addr=%h: rvalid=0, required 1", a);
    end
    step();
    rready = 0;
  endtask

  task automatic prog(input int tw, input int sh, input int dl);
    axi_write(12'h14, tw);
    axi_write(12'h18, sh);
    axi_write(12'h10, dl);
    for (int k = 0; k < M; k++) axi_write(12'(12'h40 + 4 * k), cf[k]);
  endtask

  task automatic set_frame_last(input int nlen, input int last_at);
    l_q.delete();
    for (int i = 0; i < nlen; i++) l_q.push_back(i == last_at);
  endtask

  // Drives samples one by one and collects outputs; stops early after stop_after outputs.
  task automatic run_frame(input int nin, input bit bp, input int stop_after);
    int n, t0, hold;
    bit hl, done;
    y_got.delete(); last_got.delete();
    stall_bad = 0; lat_bad = 0;
    for (int i = 0; i < nin; i++) begin
      ss_tdata = x_q[i]; ss_tlast = l_q[i]; ss_tvalid = 1; n = 0;
      while (!ss_tready && n < 300) begin step(); n++; end
      if (!ss_tready) begin
        n_total++;
        $display("FAIL ss_tready_timeout sample %0d: ss_tready=0, required 1", i);
        ss_tvalid = 0; return;
      end
      t0 = cyc;
      step();
      ss_tvalid = 0; ss_tlast = 0; n = 0;
      while (!sm_tvalid && n < 300) begin step(); n++; end
      if (!sm_tvalid) begin
        n_total++;
        $display("FAIL sm_tvalid_timeout output %0d: sm_tvalid=0, required 1", i);
        return;
      end
      if (cyc - t0 != exp_lat) lat_bad++;
      hold = int'(sm_tdata); hl = sm_tlast; done = 0; n = 0;
      while (!done) begin
        sm_tready = bp ? ($urandom_range(0, 2) == 0 || n > 20) : 1'b1;
        if (int'(sm_tdata) !== hold || sm_tlast !== hl || sm_tvalid !== 1'b1) stall_bad++;
        if (sm_tready) begin
          y_got.push_back(int'(sm_tdata));
          last_got.push_back(sm_tlast);
          done = 1;
        end
        step(); n++;
      end
      sm_tready = 0;
      if (y_got.size() == stop_after) return;
    end
  endtask

  task automatic check_frame(input string nm, input int nexp);
    int bad, lbad;
    bad = 0; lbad = 0;
    n_total++;
    if (y_got.size() !== nexp) $display("FAIL %s_count: got %0d outputs, required %0d", nm, y_got.size(), nexp);
    else n_pass++;
    for (int i = 0; i < y_got.size(); i++) begin
      if (y_got[i] !== model_y(i)) begin
        if (bad == 0) $display("FAIL %s_data y[%0d]: got %0d, required %0d", nm, i, y_got[i], model_y(i));
        bad++;
      end
      if (last_got[i] !== (i == nexp - 1)) lbad++;
    end
    n_total++; if (bad != 0) $display("FAIL %s_data_mismatches: got %0d, required 0", nm, bad); else n_pass++;
    n_total++; if (lbad != 0) $display("FAIL %s_tlast_mismatches: got %0d, required 0", nm, lbad); else n_pass++;
    n_total++; if (lat_bad != 0) $display("FAIL %s_latency: got %0d bad, required 0", nm, lat_bad); else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    axis_rst = 1;
    repeat (3) step();
    n_total++;
    if ({awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast, sm_tdata, rdata} !== '0)
      $display("FAIL reset_outputs: got aw%b w%b ar%b rv%b ss%b smv%b sml%b, required all 0",
               awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast);
    else n_pass++;
    axis_rst = 0; #1;
    n_total++;
    if ({awready, wready, arready} !== 3'b111) $display("FAIL reset_ready_after: got %b, required 111", {awready, wready, arready});
    else n_pass++;
    step();
    axi_read(12'h00, d); n_total++; if (d !== 32'h4) $display("FAIL reset_ctrl: got %h, required 4", d); else n_pass++;
    axi_read(12'h14, d); n_total++; if (d !== 32'(M)) $display("FAIL reset_tap_num: got %0d, required %0d", d, M); else n_pass++;
    axi_read(12'h10, d); n_total++; if (d !== 0) $display("FAIL reset_data_length: got %0d, required 0", d); else n_pass++;
    axi_read(12'h18, d); n_total++; if (d !== 0) $display("FAIL reset_out_shift: got %0d, required 0", d); else n_pass++;
    axi_read(12'h54, d); n_total++; if (d !== 0) $display("FAIL reset_coef5: got %0d, required 0", d); else n_pass++;
  endtask

  task automatic test_impulse();
    int ic [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int expv;
    logic [31:0] d;
    for (int k = 0; k < M; k++) cf[k] = (k < 11) ? ic[k] : 0;
    tapn = 11; shft = 0; exp_lat = 12;
    prog(11, 0, 16);
    x_q.delete(); for (int i = 0; i < 16; i++) x_q.push_back(i == 0);
    set_frame_last(16, 15);
    axi_write(12'h00, 1);
    run_frame(16, 0, 0);
    for (int i = 0; i < 16 && i < y_got.size(); i++) begin
      expv = (i < 11) ? ic[i] : 0;
      n_total++;
      if (y_got[i] !== expv) $display("FAIL impulse_y%0d: got %0d, required %0d", i, y_got[i], expv);
      else n_pass++;
    end
    check_frame("impulse", 16);
    repeat (3) step();
    axi_read(12'h00, d); n_total++; if (d !== 32'h6) $display("FAIL impulse_ctrl_done: got %h, required 6", d); else n_pass++;
  endtask

  task automatic test_taps4();
    int ev [6] = '{1, 3, 6, 10, 10, 10};
    for (int k = 0; k < M; k++) cf[k] = (k < 4) ? k + 1 : 0;
    tapn = 4; shft = 0; exp_lat = 5;
    prog(4, 0, 6);
    x_q.delete(); for (int i = 0; i < 6; i++) x_q.push_back(1);
    set_frame_last(6, 5);
    axi_write(12'h00, 1);
    run_frame(6, 0, 0);
    for (int i = 0; i < 6 && i < y_got.size(); i++) begin
      n_total++;
      if (y_got[i] !== ev[i]) $display("FAIL taps4_y%0d: got %0d, required %0d", i, y_got[i], ev[i]);
      else n_pass++;
    end
    check_frame("taps4", 6);
    repeat (3) step();
  endtask

  task automatic test_shift();
    int ev [2];
    logic [31:0] d;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < M; k++) cf[k] = (k == 0) ? 16 : 0;
      tapn = 1; shft = (pass == 0) ? 4 : 0; exp_lat = 2;
      ev[0] = (pass == 0) ? -32 : -512;
      ev[1] = (pass == 0) ? 32 : 512;
      prog(1, shft, 2);
      axi_read(12'h18, d); n_total++; if (d !== 32'(shft)) $display("FAIL shift_readback: got %0d, required %0d", d, shft); else n_pass++;
      x_q.delete(); x_q.push_back(-32); x_q.push_back(32);
      set_frame_last(2, 1);
      axi_write(12'h00, 1);
      run_frame(2, 0, 0);
      for (int i = 0; i < 2 && i < y_got.size(); i++) begin
        n_total++;
        if (y_got[i] !== ev[i]) $display("FAIL shift%0d_y%0d: got %0d, required %0d", shft, i, y_got[i], ev[i]);
        else n_pass++;
      end
      repeat (3) step();
    end
  endtask

  task automatic test_backpressure();
    int ic [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int p;
    for (int k = 0; k < M; k++) cf[k] = (k < 11) ? ic[k] : 0;
    tapn = 11; shft = 0; exp_lat = 12;
    prog(11, 0, 600);
    x_q.delete();
    for (int i = 0; i < 600; i++) begin
      p = i % 64;
      x_q.push_back((p < 32) ? p * 8 - 128 : (64 - p) * 8 - 128);
    end
    set_frame_last(600, 599);
    axi_write(12'h00, 1);
    run_frame(600, 1, 0);
    n_total++; if (stall_bad != 0) $display("FAIL bp_stall_stability: got %0d changes, required 0", stall_bad); else n_pass++;
    check_frame("bp_triangle", 600);
    repeat (3) step();
  endtask

  task automatic test_control();
    logic [31:0] d;
    for (int k = 0; k < M; k++) cf[k] = $urandom_range(0, 200) - 100;
    tapn = M; shft = 0; exp_lat = M + 1;
    prog(M, 0, 8);
    x_q.delete(); for (int i = 0; i < 8; i++) x_q.push_back($urandom_range(0, 2000) - 1000);
    set_frame_last(8, 3);
    axi_write(12'h00, 1);
    fork
      run_frame(8, 0, 0);
      begin
        repeat (10) step();
        axi_write(12'h40, 32'd12345);
        axi_write(12'h10, 32'd99);
        axi_write(12'h00, 32'd1);
      end
    join
    check_frame("ctrl_run", 8);
    repeat (3) step();
    axi_read(12'h40, d); n_total++; if (d !== 32'(cf[0])) $display("FAIL ctrl_coef_locked: got %0d, required %0d", d, cf[0]); else n_pass++;
    axi_read(12'h10, d); n_total++; if (d !== 8) $display("FAIL ctrl_len_locked: got %0d, required 8", d); else n_pass++;
    axi_read(12'h00, d); n_total++; if (d !== 32'hE) $display("FAIL ctrl_done_first_read: got %h, required e", d); else n_pass++;
    axi_read(12'h00, d); n_total++; if (d !== 32'hC) $display("FAIL ctrl_done_second_read: got %h, required c", d); else n_pass++;
    n_total++; if (ss_tready !== 1'b0) $display("FAIL ctrl_start_ignored: ss_tready=%b, required 0", ss_tready); else n_pass++;
    axi_read(12'h1C, d); n_total++; if (d !== 0) $display("FAIL ctrl_unmapped_read: got %h, required 0", d); else n_pass++;
    axi_write(12'h10, 0);
    axi_write(12'h00, 1);
    repeat (5) step();
    axi_read(12'h00, d); n_total++; if (d !== 32'h6) $display("FAIL ctrl_zero_length: got %h, required 6", d); else n_pass++;
  endtask

  task automatic test_random();
    int tw, dl;
    bit bp;
    logic [31:0] d;
    for (int it = 0; it < 3; it++) begin
      tw = (it == 0) ? 0 : (it == 1) ? 100 : $urandom_range(2, M);
      tapn = (tw == 0) ? 1 : (tw > M) ? M : tw;
      shft = $urandom_range(0, 31); dl = $urandom_range(5, 30); bp = $urandom_range(0, 1);
      exp_lat = tapn + 1;
      for (int k = 0; k < M; k++) cf[k] = int'($urandom);
      prog(tw, shft, dl);
      axi_read(12'h14, d); n_total++; if (d !== 32'(tapn)) $display("FAIL rand%0d_tap_clamp: got %0d, required %0d", it, d, tapn); else n_pass++;
      x_q.delete(); for (int i = 0; i < dl; i++) x_q.push_back(int'($urandom));
      set_frame_last(dl, dl - 1);
      axi_write(12'h00, 1);
      run_frame(dl, bp, 0);
      check_frame($sformatf("rand%0d", it), dl);
      n_total++; if (stall_bad != 0) $display("FAIL rand%0d_stall: got %0d, required 0", it, stall_bad); else n_pass++;
      repeat (3) step();
      axi_read(12'h00, d); n_total++; if (d !== 32'h6) $display("FAIL rand%0d_ctrl: got %h, required 6", it, d); else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    int hi;
    logic [31:0] d;
    for (int k = 0; k < M; k++) cf[k] = $urandom_range(0, 200) - 100;
    tapn = 4; shft = 0; exp_lat = 5;
    prog(4, 0, 20);
    x_q.delete(); for (int i = 0; i < 20; i++) x_q.push_back($urandom_range(0, 2000) - 1000);
    set_frame_last(20, 19);
    axi_write(12'h00, 1);
    run_frame(20, 0, 5);
    n_total++; if (y_got.size() !== 5) $display("FAIL midrun_pre_count: got %0d, required 5", y_got.size()); else n_pass++;
    axis_rst = 1;
    step(); step();
    axis_rst = 0;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (sm_tvalid) hi++;
      step();
    end
    n_total++; if (hi != 0) $display("FAIL midrun_outputs_stop: got %0d valid cycles, required 0", hi); else n_pass++;
    axi_read(12'h00, d); n_total++; if (d !== 32'h4) $display("FAIL midrun_ctrl_idle: got %h, required 4", d); else n_pass++;
    axi_read(12'h40, d); n_total++; if (d !== 0) $display("FAIL midrun_coef_cleared: got %0d, required 0", d); else n_pass++;
    prog(4, 0, 20);
    axi_write(12'h00, 1);
    run_frame(20, 1, 0);
    check_frame("rerun", 20);
    repeat (3) step();
    axi_read(12'h00, d); n_total++; if (d !== 32'h6) $display("FAIL rerun_ctrl: got %h, required 6", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_taps4();
    test_shift();
    test_backpressure();
    test_control();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
